memory_buffer_dp: RTL

//  Dual-port synchronous buffer memory: the responder side of the sRead/sWrite/address/inputData interface.

---
 rtl/memory_buffer_dp_pkg.sv | 49 ++++
 rtl/memory_buffer_dp_if.sv | 39 +++
 rtl/memory_buffer_dp_memory_array.sv | 31 +++
 rtl/memory_buffer_dp.sv | 117 +++++++++++
 4 files changed

// File: rtl/memory_buffer_dp_pkg.sv
// ---------------------------------------------------------------------------
// memory_buffer_dp_pkg
//   Shared definitions for the dual-port buffer memory.
//   - Default geometry (data width, address width, depth).
//   - Occupancy counter width.
//   - access_t / decode_access(): resolves one cycle's read/write request
//     against the valid bits into exactly one outcome per port.
// ---------------------------------------------------------------------------
package memory_buffer_dp_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int ADDRESS_WIDTH = 3;
    // Must equal 2**ADDRESS_WIDTH: addresses wrap with no out-of-range case.
    localparam int BUFFER_DEPTH  = 8;
    localparam int OCC_WIDTH     = ADDRESS_WIDTH + 1;

    typedef struct packed {
        logic rd_hit;   // read of a valid entry: deliver word, clear valid
        logic rd_miss;  // read of an empty entry: readErr
        logic bypass;   // same-address read+write on an empty entry
        logic wr_ok;    // write committed to the array, valid set
        logic wr_err;   // write blocked by an occupied entry: writeErr
    } access_t;

    // same_addr means addressRead == addressWrite, in which case
    // valid_r and valid_w refer to the same bit.
    function automatic access_t decode_access(
        input logic en,
        input logic wr,
        input logic rd,
        input logic same_addr,
        input logic valid_r,
        input logic valid_w
    );
        access_t a;
        logic    collide;
        collide   = en & rd & wr & same_addr;
        a.rd_hit  = en & rd & valid_r;
        a.bypass  = collide & ~valid_r;
        a.rd_miss = en & rd & ~valid_r & ~collide;
        // On a collision with a valid entry the read frees the slot first,
        // so the write is accepted; on an empty entry the word is bypassed
        // to the output and never committed.
        a.wr_ok   = collide ? valid_r : (en & wr & ~valid_w);
        a.wr_err  = en & wr & valid_w & ~collide;
        return a;
    endfunction

endpackage

// File: rtl/memory_buffer_dp_if.sv
// ---------------------------------------------------------------------------
// memory_buffer_dp_if
//   Request/response bundle between a requester (FIFO controller or tester)
//   and the buffer memory.
//   master: drives ENB, sWrite, sRead, addressWrite, addressRead, inputData;
//           observes outputData, dataValid, readErr, writeErr, occupancy,
//           full, empty.
//   slave : the buffer memory itself (reverse directions).
// ---------------------------------------------------------------------------
interface memory_buffer_dp_if
    import memory_buffer_dp_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDRESS_WIDTH
);
    logic          ENB;
    logic          sWrite;
    logic          sRead;
    logic [AW-1:0] addressWrite;
    logic [AW-1:0] addressRead;
    logic [DW-1:0] inputData;
    logic [DW-1:0] outputData;
    logic          dataValid;
    logic          readErr;
    logic          writeErr;
    logic [AW:0]   occupancy;
    logic          full;
    logic          empty;

    modport master (
        output ENB, sWrite, sRead, addressWrite, addressRead, inputData,
        input  outputData, dataValid, readErr, writeErr, occupancy, full, empty
    );

    modport slave (
        input  ENB, sWrite, sRead, addressWrite, addressRead, inputData,
        output outputData, dataValid, readErr, writeErr, occupancy, full, empty
    );
endinterface

// File: rtl/memory_buffer_dp_memory_array.sv
// ---------------------------------------------------------------------------
// memory_array
//   Storage only: one synchronous write port, one asynchronous read port.
//   No reset; contents survive a buffer reset (only the valid bits, held in
//   the parent, are cleared).
//   Ports: clk, we_i, waddr_i, wdata_i (write); raddr_i -> rdata_o (read).
// ---------------------------------------------------------------------------
module memory_array #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read: the parent registers the word, giving the
    // one-cycle read latency and read-before-write on a collision.
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/memory_buffer_dp.sv
// ---------------------------------------------------------------------------
// memory_buffer_dp
//   Dual-port buffer memory, responder side of the sRead/sWrite interface.
//   Each entry has a valid bit: a write sets it, a read clears it.
//   Ports:
//     CLK      clock, all state changes on posedge
//     RESET_L  asynchronous active-low reset (clears valid bits and outputs,
//              not the array contents)
//     bus      memory_buffer_dp_if.slave: requests in; registered
//              outputData/dataValid/readErr/writeErr/occupancy out,
//              combinational full/empty.
// ---------------------------------------------------------------------------
module memory_buffer_dp
    import memory_buffer_dp_pkg::*;
#(
    parameter int DW    = DATA_WIDTH,
    parameter int AW    = ADDRESS_WIDTH,
    parameter int DEPTH = BUFFER_DEPTH
) (
    input  logic              CLK,
    input  logic              RESET_L,
    memory_buffer_dp_if.slave bus
);
    localparam int OW = AW + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DW-1:0]    outputData_q, outputData_d;
    logic             dataValid_q, dataValid_d;
    logic             readErr_q, readErr_d;
    logic             writeErr_q, writeErr_d;
    logic [OW-1:0]    occupancy_q, occupancy_d;

    logic [DW-1:0]    mem_rdata;
    access_t          acc;

    // -----------------------------------------------------------------------
    // Access decode
    // -----------------------------------------------------------------------
    always_comb begin
        acc = decode_access(bus.ENB, bus.sWrite, bus.sRead,
                            bus.addressRead == bus.addressWrite,
                            valid_q[bus.addressRead],
                            valid_q[bus.addressWrite]);
    end

    memory_array #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (CLK),
        .we_i    (acc.wr_ok),
        .waddr_i (bus.addressWrite),
        .wdata_i (bus.inputData),
        .raddr_i (bus.addressRead),
        .rdata_o (mem_rdata)
    );

    // -----------------------------------------------------------------------
    // Valid bits: clear on read hit, then set on accepted write, so a
    // same-address hit+write leaves the entry valid.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        always_comb begin
            valid_d[gi] = valid_q[gi];
            if (acc.rd_hit && bus.addressRead == AW'(gi)) begin
                valid_d[gi] = 1'b0;
            end
            if (acc.wr_ok && bus.addressWrite == AW'(gi)) begin
                valid_d[gi] = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output and counter next-state
    // -----------------------------------------------------------------------
    always_comb begin
        outputData_d = outputData_q;
        if (acc.rd_hit) begin
            outputData_d = mem_rdata;
        end else if (acc.bypass) begin
            outputData_d = bus.inputData;
        end
        dataValid_d = acc.rd_hit | acc.bypass;
        readErr_d   = acc.rd_miss;
        writeErr_d  = acc.wr_err;
        // Valid bits bound the count to 0..DEPTH, so no saturation needed.
        occupancy_d = occupancy_q + OW'(acc.wr_ok) - OW'(acc.rd_hit);
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            valid_q      <= '0;
            outputData_q <= '0;
            dataValid_q  <= 1'b0;
            readErr_q    <= 1'b0;
            writeErr_q   <= 1'b0;
            occupancy_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            outputData_q <= outputData_d;
            dataValid_q  <= dataValid_d;
            readErr_q    <= readErr_d;
            writeErr_q   <= writeErr_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign bus.outputData = outputData_q;
    assign bus.dataValid  = dataValid_q;
    assign bus.readErr    = readErr_q;
    assign bus.writeErr   = writeErr_q;
    assign bus.occupancy  = occupancy_q;
    assign bus.full       = (occupancy_q == OW'(DEPTH));
    assign bus.empty      = (occupancy_q == '0);
endmodule
